// File: rtl/div_unit_pkg.sv
// Shared CPU definitions used by the execute-stage divider.
//   - div_state_e : divider FSM state encoding
//   - EXE_DIV_OP / EXE_DIVU_OP : ALU control codes that select DIV / DIVU
package div_unit_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_e;

   localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_unit_if.sv
// Execute-stage <-> divider handshake bundle.
//   start_i   : E-stage instruction is DIV/DIVU (held while E is stalled)
//   signed_i  : 1 = DIV, 0 = DIVU
//   annul_i   : exception flush, aborts the operation
//   opdata1_i : dividend (rs)
//   opdata2_i : divisor (rt)
//   result_o  : {remainder, quotient}, valid while ready_o
//   ready_o   : result valid this cycle
//   stall_o   : stall request to the hazard unit (mut_div_stallE)
// Modports: master = pipeline side, slave = divider side.
interface div_if #(
   parameter int WIDTH = 32
);
   logic                 start_i;
   logic                 signed_i;
   logic                 annul_i;
   logic [WIDTH-1:0]     opdata1_i;
   logic [WIDTH-1:0]     opdata2_i;
   logic [2*WIDTH-1:0]   result_o;
   logic                 ready_o;
   logic                 stall_o;

   modport master (
      output start_i, signed_i, annul_i, opdata1_i, opdata2_i,
      input  result_o, ready_o, stall_o
   );

   modport slave (
      input  start_i, signed_i, annul_i, opdata1_i, opdata2_i,
      output result_o, ready_o, stall_o
   );
endinterface

// File: rtl/div_unit_step.sv
// div_step: one combinational radix-2 restoring iteration.
//   part_i    : partial remainder {rem, next dividend bit} (WIDTH+1 bits)
//   divisor_i : divisor magnitude
//   rem_o     : next partial remainder
//   qbit_o    : quotient bit produced by this iteration
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   part_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             qbit_o
);
   logic [WIDTH:0] divisor_ext;

   always_comb begin
      divisor_ext = {1'b0, divisor_i};
      qbit_o      = (part_i >= divisor_ext);
      // The remainder is always below the divisor, so WIDTH bits suffice.
      rem_o       = qbit_o ? WIDTH'(part_i - divisor_ext) : part_i[WIDTH-1:0];
   end
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : div_if.slave handshake (start/signed/annul/operands in,
//            result/ready/stall out)
// Optional build macro DIV_SMALL_SHORTCUT_EN: when |dividend| < |divisor|
// the result {dividend, 0} is produced one cycle after accept instead of
// running the full WIDTH-step iteration.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic clk,
   input  logic resetn,
   div_if.slave bus
);
   localparam logic [CNT_W-1:0] LastStep = CNT_W'(WIDTH - 1);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quot_q, quot_d;      // dividend shift-in / quotient shift-out
   logic [WIDTH-1:0] divisor_q, divisor_d;
   logic             negq_q, negq_d;
   logic             negr_q, negr_d;

   logic [WIDTH-1:0] abs1, abs2;
   logic [WIDTH-1:0] step_rem;
   logic             step_qbit;
   logic [WIDTH-1:0] rem_fix, quot_fix;

   div_step #(.WIDTH(WIDTH)) u_step (
      .part_i   ({rem_q, quot_q[WIDTH-1]}),
      .divisor_i(divisor_q),
      .rem_o    (step_rem),
      .qbit_o   (step_qbit)
   );

   always_comb begin
      abs1 = (bus.signed_i && bus.opdata1_i[WIDTH-1]) ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
      abs2 = (bus.signed_i && bus.opdata2_i[WIDTH-1]) ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quot_d    = quot_q;
      divisor_d = divisor_q;
      negq_d    = negq_q;
      negr_d    = negr_q;

      case (state_q)
         DIV_IDLE: begin
            if (bus.start_i) begin
               if (bus.opdata2_i == '0) begin
                  // Raw dividend parked here; BYZERO moves it to the remainder.
                  quot_d  = bus.opdata1_i;
                  rem_d   = '0;
                  negq_d  = 1'b0;
                  negr_d  = 1'b0;
                  state_d = DIV_BYZERO;
               end
`ifdef DIV_SMALL_SHORTCUT_EN
               else if (abs1 < abs2) begin
                  quot_d  = '0;
                  rem_d   = bus.opdata1_i;
                  negq_d  = 1'b0;
                  negr_d  = 1'b0;
                  state_d = DIV_END;
               end
`endif
               else begin
                  quot_d    = abs1;
                  rem_d     = '0;
                  divisor_d = abs2;
                  negq_d    = bus.signed_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
                  negr_d    = bus.signed_i & bus.opdata1_i[WIDTH-1];
                  cnt_d     = '0;
                  state_d   = DIV_ON;
               end
            end
         end
         DIV_BYZERO: begin
            rem_d   = quot_q;
            quot_d  = '1;
            state_d = DIV_END;
         end
         DIV_ON: begin
            rem_d  = step_rem;
            quot_d = {quot_q[WIDTH-2:0], step_qbit};
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == LastStep) begin
               state_d = DIV_END;
            end
         end
         DIV_END: begin
            state_d = DIV_IDLE;
         end
         default: begin
            state_d = DIV_IDLE;
         end
      endcase

      if (bus.annul_i) begin
         state_d = DIV_IDLE;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= DIV_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quot_q    <= '0;
         divisor_q <= '0;
         negq_q    <= 1'b0;
         negr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quot_q    <= quot_d;
         divisor_q <= divisor_d;
         negq_q    <= negq_d;
         negr_q    <= negr_d;
      end
   end

   always_comb begin
      rem_fix  = negr_q ? (~rem_q + 1'b1) : rem_q;
      quot_fix = negq_q ? (~quot_q + 1'b1) : quot_q;
   end

   assign bus.ready_o  = (state_q == DIV_END) & ~bus.annul_i;
   assign bus.result_o = bus.ready_o ? {rem_fix, quot_fix} : '0;
   assign bus.stall_o  = (bus.start_i & ~bus.annul_i & (state_q != DIV_END))
                       | (((state_q == DIV_BYZERO) || (state_q == DIV_ON)) & ~bus.annul_i);

endmodule
